// File: rtl/ps2_key_fifo_if.sv
// CPU-side bus for the PS/2 key FIFO: read-acknowledge in, status/data word and irq out.
interface ps2_key_fifo_if;
   logic        ack;
   logic [15:0] dout;
   logic        irq;

   modport master (output ack, input dout, input irq);
   modport slave  (input ack, output dout, output irq);
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard front end: deserialise frames, drop releases/extended codes,
// map make codes to 4-bit keys and queue them behind a 16-bit status/data word.
module ps2_key_fifo #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned FILT_LEN = 8,
   parameter int unsigned TIMEOUT  = 100000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ps2c,
   input  logic           ps2d,
   ps2_key_fifo_if.slave  bus
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned FW = $clog2(FILT_LEN);
   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } rx_state_t;

   // ---------------- input conditioning ----------------
   logic [1:0]    c_sync, d_sync;
   logic          c_s, d_s;
   logic          c_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall_q;

   assign c_s = c_sync[1];
   assign d_s = d_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_sync <= '0;
         d_sync <= '0;
      end else begin
         c_sync <= {c_sync[0], ps2c};
         d_sync <= {d_sync[0], ps2d};
      end
   end

   // A new ps2c level is accepted only after FILT_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_filt   <= 1'b0;
         filt_cnt <= '0;
         fall_q   <= 1'b0;
      end else begin
         fall_q <= 1'b0;
         if (c_s == c_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            c_filt   <= c_s;
            filt_cnt <= '0;
            fall_q   <= c_filt;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // ---------------- receiver FSM ----------------
   rx_state_t     state_q, state_d;
   logic [9:0]    sr;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (fall_q && !d_s) state_d = SHIFT;
         SHIFT: begin
            if (fall_q) begin
               if (bit_cnt == 4'd9) state_d = CHECK;
            end else if (tmo_hit) begin
               state_d = IDLE;
            end
         end
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         bit_cnt <= '0;
         tmo_cnt <= '0;
      end else begin
         unique case (state_q)
            SHIFT: begin
               if (fall_q) begin
                  sr      <= {d_s, sr[9:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               bit_cnt <= '0;
               tmo_cnt <= '0;
            end
         endcase
      end
   end

   // ---------------- code decoding ----------------
   logic [7:0] rx_byte;
   logic       frame_ok;
   logic       key_hit;
   logic [3:0] key_val;
   logic       ext_q, brk_q;
   logic       push_req;
   logic [3:0] push_key;

   assign rx_byte  = sr[7:0];
   assign frame_ok = (^sr[8:0]) & sr[9];

   always_comb begin
      key_hit = 1'b1;
      key_val = 4'h0;
      unique case (rx_byte)
         8'h45:   key_val = 4'h0;
         8'h16:   key_val = 4'h1;
         8'h1E:   key_val = 4'h2;
         8'h26:   key_val = 4'h3;
         8'h25:   key_val = 4'h4;
         8'h2E:   key_val = 4'h5;
         8'h36:   key_val = 4'h6;
         8'h3D:   key_val = 4'h7;
         8'h3E:   key_val = 4'h8;
         8'h46:   key_val = 4'h9;
         8'h1D:   key_val = 4'hA;
         8'h1C:   key_val = 4'hB;
         8'h1B:   key_val = 4'hC;
         8'h23:   key_val = 4'hD;
         default: key_hit = 1'b0;
      endcase
   end

   // A break prefix swallows the following code and also cancels any extended prefix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         push_req <= 1'b0;
         push_key <= '0;
      end else begin
         push_req <= 1'b0;
         if (state_q == CHECK && frame_ok) begin
            if (rx_byte == 8'hE0) begin
               ext_q <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk_q <= 1'b1;
            end else if (brk_q) begin
               brk_q <= 1'b0;
               ext_q <= 1'b0;
            end else if (ext_q) begin
               ext_q <= 1'b0;
            end else if (key_hit) begin
               push_req <= 1'b1;
               push_key <= key_val;
            end
         end
      end
   end

   // ---------------- FIFO ----------------
   logic [3:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          ovf_q;
   logic          ack_q;
   logic          pop_req, do_pop, do_push;
   logic          empty, full;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_req = bus.ack & ~ack_q;
   assign do_pop  = pop_req & ~empty;
   // When full, a same-cycle pop frees the slot the push needs.
   assign do_push = push_req & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         ack_q <= bus.ack;
         if (do_push) begin
            mem[wr_ptr] <= push_key;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (do_pop)                 ovf_q <= 1'b0;
         else if (push_req && full)  ovf_q <= 1'b1;
      end
   end

   // ---------------- output word ----------------
   logic [4:0]  count_w;
   logic [3:0]  count_sat;
   logic [15:0] dout_q;

   assign count_w   = 5'(count);
   assign count_sat = (count_w > 5'd15) ? 4'hF : count_w[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= {~empty, ovf_q, 2'b00, count_sat, 4'b0000,
                             empty ? 4'h0 : mem[rd_ptr]};
   end

   assign bus.dout = dout_q;
   assign bus.irq  = dout_q[15];

endmodule
